adc_joystick_sampler: RTL



---
 rtl/adc_joystick_pkg.sv | 24 ++
 rtl/adc_sclk_gen.sv | 36 +++
 rtl/adc_joystick_sampler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/adc_joystick_pkg.sv
// Shared FSM state type, LTC2308 config constants and the DIN config-word helper
// used by the joystick sampler.
package adc_joystick_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SHIFT,
    S_STORE
  } state_t;

  localparam logic CFG_SD  = 1'b1;
  localparam logic CFG_UNI = 1'b1;
  localparam logic CFG_SLP = 1'b0;

  localparam int FRAME_BITS = 12;
  localparam int DATA_W     = 12;

  // LTC2308 DIN order is S/D, O/S, S1, S0, UNI, SLP; O/S is ch[0] and S1/S0 are ch[2:1].
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {CFG_SD, ch[0], ch[2], ch[1], CFG_UNI, CFG_SLP};
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock divider for the LTC2308 interface: adc_sclk toggles every CLK_DIV
// cycles while en is high, starting low, with combinational rise/fall strobes.
module adc_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic adc_sclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       phase_end;

  // Strobes are high in the cycle whose closing edge flips adc_sclk.
  assign phase_end  = en && (div_cnt == DIV_LAST);
  assign rise_pulse = phase_end && !adc_sclk;
  assign fall_pulse = phase_end && adc_sclk;

  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      div_cnt  <= '0;
      adc_sclk <= 1'b0;
    end else if (phase_end) begin
      div_cnt  <= '0;
      adc_sclk <= ~adc_sclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adc_joystick_sampler.sv
// LTC2308 channel scanner with a one-deep valid/ready output register.
// Define ADC_JOY_AVG_EN to emit 4-frame per-channel averages instead of raw results.
module adc_joystick_sampler
  import adc_joystick_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int NUM_CH    = 4,
  parameter int CONV_WAIT = 80
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic              adc_din,
  input  logic              adc_dout,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [2:0]        sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic [7:0]        drop_count
);

  localparam logic [15:0] WAIT_LAST = 16'(CONV_WAIT - 1);
  localparam logic [2:0]  CH_LAST   = 3'(NUM_CH - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(FRAME_BITS - 1);

  state_t                  state;
  logic [15:0]             wait_cnt;
  logic [3:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   tx_sr;
  logic [FRAME_BITS-1:0]   rx_sr;
  logic [2:0]              cfg_ch;
  logic [2:0]              prev_ch;
  logic                    priming;
  logic                    rise_pulse;
  logic                    fall_pulse;
  logic                    emit;
  logic [DATA_W-1:0]       emit_data;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (state == S_SHIFT),
    .adc_sclk   (adc_sclk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

`ifdef ADC_JOY_AVG_EN
  logic [13:0] acc [8];
  logic [1:0]  acc_cnt [8];
  logic [13:0] acc_sum;

  // The fourth frame of a channel emits its sum/4 and restarts that accumulator.
  assign acc_sum   = acc[prev_ch] + 14'(rx_sr);
  assign emit      = !priming && (acc_cnt[prev_ch] == 2'd3);
  assign emit_data = acc_sum[13:2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        acc[i]     <= '0;
        acc_cnt[i] <= '0;
      end
    end else if (state == S_STORE && !priming) begin
      if (acc_cnt[prev_ch] == 2'd3) begin
        acc[prev_ch]     <= '0;
        acc_cnt[prev_ch] <= '0;
      end else begin
        acc[prev_ch]     <= acc_sum;
        acc_cnt[prev_ch] <= acc_cnt[prev_ch] + 2'd1;
      end
    end
  end
`else
  assign emit      = !priming;
  assign emit_data = rx_sr;
`endif

  // Data in a frame belongs to prev_ch because the LTC2308 converts the channel
  // configured one frame earlier; the first frame of a scan run is discarded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      adc_cs_n     <= 1'b0;
      adc_din      <= 1'b0;
      wait_cnt     <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      cfg_ch       <= '0;
      prev_ch      <= '0;
      priming      <= 1'b1;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      drop_count   <= '0;
    end else begin
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          adc_cs_n <= 1'b0;
          adc_din  <= 1'b0;
          if (enable) begin
            state    <= S_CONV;
            adc_cs_n <= 1'b1;
            wait_cnt <= '0;
          end else begin
            priming <= 1'b1;
          end
        end

        S_CONV: begin
          if (wait_cnt == WAIT_LAST) begin
            state                <= S_SHIFT;
            adc_cs_n             <= 1'b0;
            bit_cnt              <= '0;
            {adc_din, tx_sr}     <= {cfg_word(cfg_ch), {(FRAME_BITS - 5){1'b0}}};
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_SHIFT: begin
          if (rise_pulse) begin
            rx_sr <= {rx_sr[FRAME_BITS-2:0], adc_dout};
          end
          if (fall_pulse) begin
            adc_din <= tx_sr[FRAME_BITS-1];
            tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              state <= S_STORE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        S_STORE: begin
          if (emit) begin
            if (!sample_valid || sample_ready) begin
              sample_valid <= 1'b1;
              sample_data  <= emit_data;
              sample_ch    <= prev_ch;
            end else if (drop_count != 8'hFF) begin
              drop_count <= drop_count + 8'd1;
            end
          end
          priming <= 1'b0;
          prev_ch <= cfg_ch;
          cfg_ch  <= (cfg_ch == CH_LAST) ? 3'd0 : cfg_ch + 3'd1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
